// File: rtl/ray_sphere_nearest.sv
// ray_sphere_nearest: nearest positive ray/sphere hit against a small sphere table, one sphere per cycle.
// Latency: result valid NUM_SPHERES+1 cycles after ray acceptance; one ray per NUM_SPHERES+2 cycles.
// Backpressure: result held in DONE until outReady; inReady low and table writes ignored while busy.
module ray_sphere_nearest #(
  parameter int WIDTH       = 12,
  parameter int FRAC        = 4,
  parameter int NUM_SPHERES = 4,
  parameter int IDXW        = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic signed [WIDTH-1:0] ox,
  input  logic signed [WIDTH-1:0] oy,
  input  logic signed [WIDTH-1:0] oz,
  input  logic signed [WIDTH-1:0] dx,
  input  logic signed [WIDTH-1:0] dy,
  input  logic signed [WIDTH-1:0] dz,
  output logic                    outValid,
  input  logic                    outReady,
  output logic                    hit,
  output logic signed [WIDTH-1:0] t,
  output logic [IDXW-1:0]         sphereId,
  output logic                    busy,
  input  logic                    sphWrEn,
  input  logic [IDXW-1:0]         sphWrAddr,
  input  logic signed [WIDTH-1:0] sphWrCx,
  input  logic signed [WIDTH-1:0] sphWrCy,
  input  logic signed [WIDTH-1:0] sphWrCz,
  input  logic signed [WIDTH-1:0] sphWrR,
  input  logic                    sphWrOn
);

  // Wide enough for a 3-term dot product, the <<FRAC before division and the sqrt argument.
  localparam int XW = 2*WIDTH + 2*FRAC + 4;
  typedef logic signed [XW-1:0]    wide_t;
  typedef logic signed [WIDTH-1:0] fix_t;
  localparam wide_t SMAX = (wide_t'(1) <<< (WIDTH-1)) - wide_t'(1);
  localparam wide_t SMIN = -(wide_t'(1) <<< (WIDTH-1));
  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_SPHERES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  function automatic wide_t ext(input fix_t v);
    return wide_t'(v);
  endfunction

  function automatic fix_t sat(input wide_t v);
    if (v > SMAX)      return fix_t'(SMAX);
    else if (v < SMIN) return fix_t'(SMIN);
    else               return fix_t'(v);
  endfunction

  // Digit-by-digit integer square root (floor); argument is non-negative when used.
  function automatic wide_t isqrt(input wide_t v);
    wide_t rem;
    wide_t root;
    wide_t bv;
    rem  = v;
    root = '0;
    bv   = wide_t'(1) <<< (XW-2);
    for (int i = 0; i < XW/2; i++) begin
      if (rem >= root + bv) begin
        rem  = rem - (root + bv);
        root = (root >>> 1) + bv;
      end else begin
        root = root >>> 1;
      end
      bv = bv >>> 2;
    end
    return root;
  endfunction

  state_t state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic best_hit_q, best_hit_d;
  fix_t best_t_q, best_t_d;
  logic [IDXW-1:0] best_id_q, best_id_d;
  fix_t ox_q, oy_q, oz_q, dx_q, dy_q, dz_q;
  fix_t ox_d, oy_d, oz_d, dx_d, dy_d, dz_d;

  fix_t cx_q [NUM_SPHERES];
  fix_t cy_q [NUM_SPHERES];
  fix_t cz_q [NUM_SPHERES];
  fix_t r_q  [NUM_SPHERES];
  logic [NUM_SPHERES-1:0] en_q;

  logic wr_ok;
  fix_t cx, cy, cz, rr;
  fix_t lx, ly, lz, a_f, hb_f, ll_f, r2_f, cq_f, hh_f, acq_f, disc_f, s_f;
  fix_t n0, n1, t0, t1, cand;
  wide_t div;
  logic cand_vld, sph_hit;

  assign wr_ok = sphWrEn && (state_q == S_IDLE) && (int'(sphWrAddr) < NUM_SPHERES);

  // Control FSM: next state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    inReady  = 1'b0;
    outValid = 1'b0;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        inReady = 1'b1;
        if (inValid) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (idx_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        outValid = 1'b1;
        if (outReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-sphere intersection of the latched ray against table entry idx_q.
  always_comb begin
    cx     = cx_q[idx_q];
    cy     = cy_q[idx_q];
    cz     = cz_q[idx_q];
    rr     = r_q[idx_q];
    lx     = sat(ext(ox_q) - ext(cx));
    ly     = sat(ext(oy_q) - ext(cy));
    lz     = sat(ext(oz_q) - ext(cz));
    a_f    = sat((ext(dx_q)*ext(dx_q) + ext(dy_q)*ext(dy_q) + ext(dz_q)*ext(dz_q)) >>> FRAC);
    hb_f   = sat((ext(lx)*ext(dx_q) + ext(ly)*ext(dy_q) + ext(lz)*ext(dz_q)) >>> FRAC);
    ll_f   = sat((ext(lx)*ext(lx) + ext(ly)*ext(ly) + ext(lz)*ext(lz)) >>> FRAC);
    r2_f   = sat((ext(rr)*ext(rr)) >>> FRAC);
    cq_f   = sat(ext(ll_f) - ext(r2_f));
    hh_f   = sat((ext(hb_f)*ext(hb_f)) >>> FRAC);
    acq_f  = sat((ext(a_f)*ext(cq_f)) >>> FRAC);
    disc_f = sat(ext(hh_f) - ext(acq_f));
    s_f    = sat(isqrt(ext(disc_f) <<< FRAC));
    // -hb +/- s is one add/sub, so it saturates once.
    n0     = sat(-ext(hb_f) - ext(s_f));
    n1     = sat(-ext(hb_f) + ext(s_f));
    // Guard the divisor; a<=0 is a miss anyway.
    div    = (a_f > 0) ? ext(a_f) : wide_t'(1);
    t0     = sat((ext(n0) <<< FRAC) / div);
    t1     = sat((ext(n1) <<< FRAC) / div);
    cand     = t0;
    cand_vld = 1'b1;
    if (t0 > 0 && t1 > 0) cand = (t1 < t0) ? t1 : t0;
    else if (t0 > 0)      cand = t0;
    else if (t1 > 0)      cand = t1;
    else                  cand_vld = 1'b0;
    sph_hit = en_q[idx_q] && (disc_f >= 0) && (a_f > 0) && cand_vld;
  end

  // Ray latch, sphere index and running nearest-hit tracking.
  always_comb begin
    idx_d      = idx_q;
    best_hit_d = best_hit_q;
    best_t_d   = best_t_q;
    best_id_d  = best_id_q;
    ox_d = ox_q; oy_d = oy_q; oz_d = oz_q;
    dx_d = dx_q; dy_d = dy_q; dz_d = dz_q;
    if (state_q == S_IDLE && inValid) begin
      ox_d = ox; oy_d = oy; oz_d = oz;
      dx_d = dx; dy_d = dy; dz_d = dz;
      idx_d      = '0;
      best_hit_d = 1'b0;
      best_t_d   = '0;
      best_id_d  = '0;
    end else if (state_q == S_EVAL) begin
      // Strict less-than keeps the lower index on equal distance.
      if (sph_hit && (!best_hit_q || cand < best_t_q)) begin
        best_hit_d = 1'b1;
        best_t_d   = cand;
        best_id_d  = idx_q;
      end
      if (idx_q != LAST) idx_d = idx_q + 1'b1;
    end
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      best_hit_q <= 1'b0;
      best_t_q   <= '0;
      best_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_hit_q <= best_hit_d;
      best_t_q   <= best_t_d;
      best_id_q  <= best_id_d;
    end
  end

  // Latched ray; only meaningful after acceptance, so no reset.
  always_ff @(posedge clk) begin
    ox_q <= ox_d; oy_q <= oy_d; oz_q <= oz_d;
    dx_q <= dx_d; dy_q <= dy_d; dz_q <= dz_d;
  end

  // Sphere geometry storage; contents are don't-care until enabled.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      cx_q[sphWrAddr] <= sphWrCx;
      cy_q[sphWrAddr] <= sphWrCy;
      cz_q[sphWrAddr] <= sphWrCz;
      r_q[sphWrAddr]  <= sphWrR;
    end
  end

  // Entry enables; reset disables the whole table.
  always_ff @(posedge clk) begin
    if (!rst_n)     en_q <= '0;
    else if (wr_ok) en_q[sphWrAddr] <= sphWrOn;
  end

  assign hit      = outValid & best_hit_q;
  assign t        = outValid ? best_t_q : '0;
  assign sphereId = outValid ? best_id_q : '0;

endmodule

// File: tb/tb_ray_sphere_nearest.sv
// Bench for ray_sphere_nearest: directed scenes, handshake, back-to-back, random scenes, reset mid-ray.
// Expected results come from an integer reference model of the intersection rules.
// Results are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_ray_sphere_nearest;
  localparam int W  = 12;
  localparam int F  = 4;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic inValid, inReady, outValid, outReady, hit, busy;
  logic signed [W-1:0] ox, oy, oz, dx, dy, dz, t;
  logic [IW-1:0] sphereId;
  logic sphWrEn, sphWrOn;
  logic [IW-1:0] sphWrAddr;
  logic signed [W-1:0] sphWrCx, sphWrCy, sphWrCz, sphWrR;

  int n_tests = 0;
  int n_fail  = 0;

  int m_cx [N];
  int m_cy [N];
  int m_cz [N];
  int m_r  [N];
  bit m_on [N];

  always #5 clk = ~clk;

  ray_sphere_nearest #(.WIDTH(W), .FRAC(F), .NUM_SPHERES(N), .IDXW(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .inValid(inValid), .inReady(inReady),
    .ox(ox), .oy(oy), .oz(oz), .dx(dx), .dy(dy), .dz(dz),
    .outValid(outValid), .outReady(outReady),
    .hit(hit), .t(t), .sphereId(sphereId), .busy(busy),
    .sphWrEn(sphWrEn), .sphWrAddr(sphWrAddr),
    .sphWrCx(sphWrCx), .sphWrCy(sphWrCy), .sphWrCz(sphWrCz), .sphWrR(sphWrR),
    .sphWrOn(sphWrOn)
  );

  // ---------------- reference model ----------------
  function automatic longint satw(longint v);
    longint hi;
    longint lo;
    hi = (longint'(1) << (W-1)) - 1;
    lo = -(longint'(1) << (W-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint isq(longint v);
    longint s;
    s = 0;
    while ((s+1)*(s+1) <= v) s++;
    return s;
  endfunction

  function automatic longint fmul(longint a, longint b);
    return satw((a*b) >>> F);
  endfunction

  function automatic longint fdot(longint a0, longint a1, longint a2,
                                  longint b0, longint b1, longint b2);
    return satw((a0*b0 + a1*b1 + a2*b2) >>> F);
  endfunction

  task automatic model_ray(input longint rox, roy, roz, rdx, rdy, rdz,
                           output bit eh, output longint et, output int eid);
    longint lx, ly, lz, a, hb, cq, disc, s, q0, q1, c;
    bit cv;
    eh = 0; et = 0; eid = 0;
    for (int i = 0; i < N; i++) begin
      if (!m_on[i]) continue;
      lx   = satw(rox - m_cx[i]);
      ly   = satw(roy - m_cy[i]);
      lz   = satw(roz - m_cz[i]);
      a    = fdot(rdx, rdy, rdz, rdx, rdy, rdz);
      hb   = fdot(lx, ly, lz, rdx, rdy, rdz);
      cq   = satw(fdot(lx, ly, lz, lx, ly, lz) - fmul(m_r[i], m_r[i]));
      disc = satw(fmul(hb, hb) - fmul(a, cq));
      if (disc < 0 || a <= 0) continue;
      s  = isq(disc * (1 << F));
      q0 = satw((satw(-hb - s) * (1 << F)) / a);
      q1 = satw((satw(-hb + s) * (1 << F)) / a);
      cv = 1; c = 0;
      if (q0 > 0 && q1 > 0) c = (q0 < q1) ? q0 : q1;
      else if (q0 > 0) c = q0;
      else if (q1 > 0) c = q1;
      else cv = 0;
      if (cv && (!eh || c < et)) begin
        eh = 1; et = c; eid = i;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic write_sph(input int a, cx, cy, cz, r, input bit on);
    sphWrEn = 1'b1; sphWrAddr = IW'(a);
    sphWrCx = W'(cx); sphWrCy = W'(cy); sphWrCz = W'(cz); sphWrR = W'(r);
    sphWrOn = on;
    @(posedge clk); #1;
    sphWrEn = 1'b0;
    m_cx[a] = cx; m_cy[a] = cy; m_cz[a] = cz; m_r[a] = r; m_on[a] = on;
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) write_sph(i, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic send_ray(input int rox, roy, roz, rdx, rdy, rdz,
                          output logic o_hit, output logic signed [W-1:0] o_t,
                          output logic [IW-1:0] o_id, output int lat);
    ox = W'(rox); oy = W'(roy); oz = W'(roz);
    dx = W'(rdx); dy = W'(rdy); dz = W'(rdz);
    inValid = 1'b1; outReady = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    lat = 1;
    while (outValid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (outValid !== 1'b1) lat = -1;
    o_hit = hit; o_t = t; o_id = sphereId;
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
  endtask

  function automatic int srnd(int k);
    return int'($urandom_range(2*k, 0)) - k;
  endfunction

  // ---------------- scenarios ----------------
  logic r_hit;
  logic signed [W-1:0] r_t;
  logic [IW-1:0] r_id;
  int r_lat;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < N; i++) m_on[i] = 0;
    n_tests++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL reset_outValid got=%b want=0", outValid); end
    n_tests++; if (inReady !== 1'b1) begin n_fail++; $display("FAIL reset_inReady got=%b want=1", inReady); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got=%b want=0", hit); end
    n_tests++; if (t !== 12'sd0) begin n_fail++; $display("FAIL reset_t got=%0d want=0", t); end
    n_tests++; if (sphereId !== 2'd0) begin n_fail++; $display("FAIL reset_id got=%0d want=0", sphereId); end
  endtask

  task automatic test_single();
    clear_table();
    write_sph(0, 0, 0, 160, 32, 1'b1);
    send_ray(0, 0, 0, 0, 0, 16, r_hit, r_t, r_id, r_lat);
    n_tests++; if (r_lat != N+1) begin n_fail++; $display("FAIL single_latency got=%0d want=%0d", r_lat, N+1); end
    n_tests++; if (r_hit !== 1'b1) begin n_fail++; $display("FAIL single_hit got=%b want=1", r_hit); end
    n_tests++; if (r_t !== 12'sd128) begin n_fail++; $display("FAIL single_t got=%0d want=128", r_t); end
    n_tests++; if (r_id !== 2'd0) begin n_fail++; $display("FAIL single_id got=%0d want=0", r_id); end
  endtask

  task automatic test_nearest();
    write_sph(1, 0, 0, 80, 16, 1'b1);
    send_ray(0, 0, 0, 0, 0, 16, r_hit, r_t, r_id, r_lat);
    n_tests++; if (r_hit !== 1'b1) begin n_fail++; $display("FAIL nearest_hit got=%b want=1", r_hit); end
    n_tests++; if (r_t !== 12'sd64) begin n_fail++; $display("FAIL nearest_t got=%0d want=64", r_t); end
    n_tests++; if (r_id !== 2'd1) begin n_fail++; $display("FAIL nearest_id got=%0d want=1", r_id); end
  endtask

  task automatic test_miss();
    write_sph(0, 0, 0, 160, 32, 1'b0);
    write_sph(1, 0, 0, 80, 16, 1'b0);
    write_sph(2, 80, 0, 160, 16, 1'b1);
    send_ray(0, 0, 0, 0, 0, 16, r_hit, r_t, r_id, r_lat);
    n_tests++; if (r_hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit got=%b want=0", r_hit); end
    n_tests++; if (r_t !== 12'sd0) begin n_fail++; $display("FAIL miss_t got=%0d want=0", r_t); end
    n_tests++; if (r_id !== 2'd0) begin n_fail++; $display("FAIL miss_id got=%0d want=0", r_id); end
    write_sph(2, 80, 0, 160, 16, 1'b0);
    send_ray(0, 0, 0, 0, 0, 16, r_hit, r_t, r_id, r_lat);
    n_tests++; if (r_hit !== 1'b0) begin n_fail++; $display("FAIL alloff_hit got=%b want=0", r_hit); end
  endtask

  task automatic test_inside_and_tie();
    write_sph(0, 0, 0, 0, 32, 1'b1);
    send_ray(0, 0, 0, 0, 0, 16, r_hit, r_t, r_id, r_lat);
    n_tests++; if (r_hit !== 1'b1) begin n_fail++; $display("FAIL inside_hit got=%b want=1", r_hit); end
    n_tests++; if (r_t !== 12'sd32) begin n_fail++; $display("FAIL inside_t got=%0d want=32", r_t); end
    write_sph(0, 0, 0, 0, 32, 1'b0);
    write_sph(2, 0, 0, 160, 32, 1'b1);
    write_sph(3, 0, 0, 160, 32, 1'b1);
    send_ray(0, 0, 0, 0, 0, 16, r_hit, r_t, r_id, r_lat);
    n_tests++; if (r_t !== 12'sd128) begin n_fail++; $display("FAIL tie_t got=%0d want=128", r_t); end
    n_tests++; if (r_id !== 2'd2) begin n_fail++; $display("FAIL tie_id got=%0d want=2", r_id); end
  endtask

  task automatic test_handshake();
    int waitc;
    ox = '0; oy = '0; oz = '0; dx = '0; dy = '0; dz = 12'sd16;
    inValid = 1'b1; outReady = 1'b0;
    @(posedge clk); #1;
    // Different ray offered and a nearer sphere written while busy: both must be ignored.
    ox = 12'sd100; dz = -12'sd16;
    sphWrEn = 1'b1; sphWrAddr = 2'd0; sphWrCx = '0; sphWrCy = '0; sphWrCz = 12'sd32;
    sphWrR = 12'sd16; sphWrOn = 1'b1;
    waitc = 0;
    while (outValid !== 1'b1 && waitc < 40) begin @(posedge clk); #1; waitc++; end
    n_tests++; if (outValid !== 1'b1) begin n_fail++; $display("FAIL hs_done_reached got=%b want=1", outValid); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_tests++; if (outValid !== 1'b1) begin n_fail++; $display("FAIL hs_hold_valid cyc=%0d got=%b want=1", c, outValid); end
      n_tests++; if (inReady !== 1'b0) begin n_fail++; $display("FAIL hs_hold_inReady cyc=%0d got=%b want=0", c, inReady); end
      n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL hs_hold_hit cyc=%0d got=%b want=1", c, hit); end
      n_tests++; if (t !== 12'sd128) begin n_fail++; $display("FAIL hs_hold_t cyc=%0d got=%0d want=128", c, t); end
      n_tests++; if (sphereId !== 2'd2) begin n_fail++; $display("FAIL hs_hold_id cyc=%0d got=%0d want=2", c, sphereId); end
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0; inValid = 1'b0; sphWrEn = 1'b0;
    n_tests++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL hs_release_valid got=%b want=0", outValid); end
    n_tests++; if (inReady !== 1'b1) begin n_fail++; $display("FAIL hs_release_inReady got=%b want=1", inReady); end
    send_ray(0, 0, 0, 0, 0, 16, r_hit, r_t, r_id, r_lat);
    n_tests++; if (r_t !== 12'sd128) begin n_fail++; $display("FAIL hs_busywrite_t got=%0d want=128", r_t); end
    n_tests++; if (r_id !== 2'd2) begin n_fail++; $display("FAIL hs_busywrite_id got=%0d want=2", r_id); end
  endtask

  task automatic test_back_to_back();
    int seen [$];
    bit eh; longint et; int eid;
    model_ray(0, 0, 0, 0, 0, 16, eh, et, eid);
    ox = '0; oy = '0; oz = '0; dx = '0; dy = '0; dz = 12'sd16;
    inValid = 1'b1; outReady = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      if (outValid === 1'b1) begin
        seen.push_back(c);
        n_tests++; if (t !== W'(et)) begin n_fail++; $display("FAIL b2b_t cyc=%0d got=%0d want=%0d", c, t, et); end
      end
    end
    inValid = 1'b0; outReady = 1'b0;
    n_tests++; if (seen.size() != 3) begin n_fail++; $display("FAIL b2b_count got=%0d want=3", seen.size()); end
    for (int k = 0; k < seen.size() && k < 3; k++) begin
      n_tests++; if (seen[k] != 5 + 6*k) begin n_fail++; $display("FAIL b2b_cycle k=%0d got=%0d want=%0d", k, seen[k], 5 + 6*k); end
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_random();
    int rox, roy, roz, rdx, rdy, rdz, k;
    bit eh; longint et; int eid;
    for (int it = 0; it < 30; it++) begin
      if (it % 5 == 0) begin
        for (int i = 0; i < N; i++)
          write_sph(i, srnd(160), srnd(160), srnd(160), int'($urandom_range(64, 8)), ($urandom_range(3, 0) != 0));
      end
      rox = srnd(80); roy = srnd(80); roz = srnd(80);
      if (it % 2 == 0) begin
        k = int'($urandom_range(N-1, 0));
        rdx = (m_cx[k] - rox) / 8 + srnd(2);
        rdy = (m_cy[k] - roy) / 8 + srnd(2);
        rdz = (m_cz[k] - roz) / 8 + srnd(2);
      end else begin
        rdx = srnd(24); rdy = srnd(24); rdz = srnd(24);
      end
      model_ray(rox, roy, roz, rdx, rdy, rdz, eh, et, eid);
      send_ray(rox, roy, roz, rdx, rdy, rdz, r_hit, r_t, r_id, r_lat);
      n_tests++; if (r_lat != N+1) begin n_fail++; $display("FAIL rnd_latency it=%0d got=%0d want=%0d", it, r_lat, N+1); end
      n_tests++; if (r_hit !== eh) begin n_fail++; $display("FAIL rnd_hit it=%0d got=%b want=%b", it, r_hit, eh); end
      n_tests++; if (r_t !== W'(et)) begin n_fail++; $display("FAIL rnd_t it=%0d got=%0d want=%0d", it, r_t, et); end
      n_tests++; if (r_id !== IW'(eid)) begin n_fail++; $display("FAIL rnd_id it=%0d got=%0d want=%0d", it, r_id, eid); end
    end
  endtask

  task automatic test_reset_mid_eval();
    write_sph(0, 0, 0, 160, 32, 1'b1);
    ox = '0; oy = '0; oz = '0; dx = '0; dy = '0; dz = 12'sd16;
    inValid = 1'b1; outReady = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) m_on[i] = 0;
    n_tests++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL rstmid_outValid got=%b want=0", outValid); end
    n_tests++; if (inReady !== 1'b1) begin n_fail++; $display("FAIL rstmid_inReady got=%b want=1", inReady); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_result got=%b want=0", outValid); end
    send_ray(0, 0, 0, 0, 0, 16, r_hit, r_t, r_id, r_lat);
    n_tests++; if (r_lat != N+1) begin n_fail++; $display("FAIL rstmid_latency got=%0d want=%0d", r_lat, N+1); end
    n_tests++; if (r_hit !== 1'b0) begin n_fail++; $display("FAIL rstmid_hit got=%b want=0", r_hit); end
  endtask

  initial begin
    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b0;
    ox = '0; oy = '0; oz = '0; dx = '0; dy = '0; dz = '0;
    sphWrEn = 1'b0; sphWrAddr = '0; sphWrOn = 1'b0;
    sphWrCx = '0; sphWrCy = '0; sphWrCz = '0; sphWrR = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_nearest();
    test_miss();
    test_inside_and_tie();
    test_handshake();
    test_back_to_back();
    test_random();
    test_reset_mid_eval();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ray_sphere_nearest.md
Name: ray_sphere_nearest

Overview:
Parametrised, sequential ray-vs-scene intersector for the ray pipeline. It holds a table of up to NUM_SPHERES spheres in the signed fixed-point format Q(WIDTH-FRAC).FRAC. It accepts one ray at a time over a valid/ready handshake, tests the ray against every enabled sphere at one sphere per cycle, and returns the nearest positive hit distance and the index of the sphere that produced it. The result is held until the downstream stage accepts it.

Parameters:
WIDTH, 12, total bits of every signed fixed-point quantity
FRAC, 4, fractional bits (1.0 = 2^FRAC)
NUM_SPHERES, 4, sphere table depth (>=1)
IDXW, $clog2(NUM_SPHERES) min 1, sphere index width

Ports:
clk  in  1  clock, all state updates on its rising edge
rst_n  in  1  synchronous active-low reset
inValid  in  1  ray presented
inReady  out  1  block can accept a ray
ox, oy, oz  in  WIDTH each  ray origin, signed
dx, dy, dz  in  WIDTH each  ray direction, signed
outValid  out  1  result presented
outReady  in  1  downstream accepts result
hit  out  1  at least one enabled sphere hit with t>0
t  out  WIDTH  nearest positive t, signed; 0 when hit=0
sphereId  out  IDXW  index of nearest sphere; 0 when hit=0
busy  out  1  high whenever state != IDLE
sphWrEn  in  1  table write strobe
sphWrAddr  in  IDXW  table entry to write
sphWrCx, sphWrCy, sphWrCz, sphWrR  in  WIDTH each  sphere centre and radius
sphWrOn  in  1  entry enable bit to store

Behaviour:
- Interface: single clock clk; reset rst_n is synchronous and active-low.
- Reset: state=IDLE, outValid=0, hit=0, t=0, sphereId=0, busy=0, and every table enable bit cleared. Table data is don't-care. Reset in any state aborts the current ray without producing a result.
- Table writes: accepted only in IDLE. Ignored while busy. Ignored when sphWrAddr>=NUM_SPHERES. The write is visible to the next accepted ray.
- FSM:
  - IDLE: inReady=1. On inValid, latch the ray, clear best (bestHit=0, bestT=0, bestId=0), set idx=0, go to EVAL.
  - EVAL: evaluate entry idx. If idx==NUM_SPHERES-1, go to DONE; else increment idx. Exactly NUM_SPHERES cycles.
  - DONE: outValid=1 with hit=bestHit, t=bestT, sphereId=bestId, held stable. On outReady, go to IDLE. inReady=0 outside IDLE.
- Latency: ray accepted in cycle 0, outValid asserted in cycle NUM_SPHERES+1. Back-to-back throughput is one ray per NUM_SPHERES+2 cycles when outReady=1.
- Arithmetic (all signed):
  - Every add/sub result and every product>>>FRAC saturates to the WIDTH range.
  - Products are formed at full 2*WIDTH precision before the arithmetic shift.
  - Dot products sum the three full-precision products, then shift and saturate once.
- Per-sphere evaluation:
  - l = o - c.
  - a = d·d.
  - hb = l·d.
  - cq = sat(l·l - r*r).
  - disc = sat(hb*hb - a*cq).
  - Miss if the entry is disabled, disc<0, or a<=0.
  - s = floor(sqrt(disc<<FRAC)).
  - t0 = sat(((-hb - s)<<FRAC)/a) and t1 = sat(((-hb + s)<<FRAC)/a), both truncating toward zero.
  - Candidate is the smallest of {t0, t1} that is >0. No candidate means miss.
- Nearest selection: update best when the candidate exists and (bestHit==0 or candidate<bestT), using strict less-than. On equal t, the lowest index wins.
- inValid while busy is not accepted; the upstream stage holds the ray. If outReady is high on the first DONE cycle, the block completes and returns to IDLE in that same cycle.

Test Plan:
(WIDTH=12, FRAC=4, NUM_SPHERES=4; values in real units, raw = real*16; ray o=(0,0,0), d=(0,0,1) unless stated.)
- Single sphere: entry 0 c=(0,0,10) r=2 enabled, others disabled -> outValid in cycle 5, hit=1, t=8.0 (raw 128), sphereId=0.
- Nearest: also load entry 1 c=(0,0,5) r=1 -> hit=1, t=4.0 (raw 64), sphereId=1.
- Miss and disabled entries: only entry 2 c=(5,0,10) r=1 enabled (disc=-24), plus entry 0 disabled -> hit=0, t=0, sphereId=0. The same ray with all entries disabled -> hit=0.
- Origin inside sphere: entry 0 c=(0,0,0) r=2 (t0=-2, t1=2) -> hit=1, t=2.0. Tie: entries 2 and 3 both c=(0,0,10) r=2 -> t=8.0, sphereId=2.
- Handshake: hold outReady=0 for 5 cycles in DONE -> outputs stable, inReady=0, a new inValid is not taken. A table write issued while busy is ignored (the next ray's result is unchanged).
- Reset mid-EVAL: drive rst_n=0 for 1 cycle at idx=2 -> the next cycle shows state IDLE, outValid=0, inReady=1, and all entries disabled (the following ray returns hit=0).
